// File: rtl/cdc_handshake_sync_pkg.sv
// Shared types for the req/ack handshake synchronizer.
// Holds the FSM state encodings and the default word width.
`timescale 1ns/10ps
package cdc_handshake_sync_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    SRC_IDLE = 2'd0,
    SRC_REQ  = 2'd1,
    SRC_DROP = 2'd2
  } src_state_t;

  typedef enum logic [1:0] {
    DST_IDLE = 2'd0,
    DST_HOLD = 2'd1,
    DST_ACK  = 2'd2
  } dst_state_t;

endpackage

// File: rtl/cdc_handshake_sync_sync_2ff.sv
// Two-flop single-bit synchronizer.
// Active-low asynchronous reset clears both flops.
`timescale 1ns/10ps
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cdc_handshake_sync.sv
// Four-phase req/ack word transfer between two clock domains.
// Only req and ack are synchronized; the data bus is held stable instead.
`timescale 1ns/10ps
module cdc_handshake_sync
  import cdc_handshake_sync_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_src,
  input  logic              rst_src,
  input  logic              clk_dst,
  input  logic              rst_dst,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_busy,
  output logic              dst_valid,
  input  logic              dst_ready,
  output logic [DATA_W-1:0] dst_data
);

  src_state_t        src_st, src_nxt;
  dst_state_t        dst_st, dst_nxt;
  logic              req, req_nxt, req_sync;
  logic              ack, ack_nxt, ack_sync;
  logic [DATA_W-1:0] src_data_q, sdata_nxt;
  logic [DATA_W-1:0] ddata_nxt;
  logic              dvalid_nxt;

  sync_2ff u_req_sync (
    .clk   (clk_dst),
    .rst_n (rst_dst),
    .d     (req),
    .q     (req_sync)
  );

  sync_2ff u_ack_sync (
    .clk   (clk_src),
    .rst_n (rst_src),
    .d     (ack),
    .q     (ack_sync)
  );

  always_ff @(posedge clk_src or negedge rst_src) begin
    if (!rst_src) begin
      src_st     <= SRC_IDLE;
      req        <= 1'b0;
      src_data_q <= '0;
    end else begin
      src_st     <= src_nxt;
      req        <= req_nxt;
      src_data_q <= sdata_nxt;
    end
  end

  always_comb begin
    src_nxt   = src_st;
    req_nxt   = req;
    sdata_nxt = src_data_q;
    src_ready = 1'b0;
    unique case (src_st)
      SRC_IDLE: begin
        src_ready = !ack_sync;
        if (src_valid && !ack_sync) begin
          sdata_nxt = src_data;
          req_nxt   = 1'b1;
          src_nxt   = SRC_REQ;
        end
      end
      SRC_REQ: begin
        if (ack_sync) begin
          req_nxt = 1'b0;
          src_nxt = SRC_DROP;
        end
      end
      SRC_DROP: begin
        if (!ack_sync) src_nxt = SRC_IDLE;
      end
      default: src_nxt = SRC_IDLE;
    endcase
  end

  assign src_busy = (src_st != SRC_IDLE);

  always_ff @(posedge clk_dst or negedge rst_dst) begin
    if (!rst_dst) begin
      dst_st    <= DST_IDLE;
      ack       <= 1'b0;
      dst_valid <= 1'b0;
      dst_data  <= '0;
    end else begin
      dst_st    <= dst_nxt;
      ack       <= ack_nxt;
      dst_valid <= dvalid_nxt;
      dst_data  <= ddata_nxt;
    end
  end

  // src_data_q is frozen while req is high, so sampling it here is safe
  always_comb begin
    dst_nxt    = dst_st;
    ack_nxt    = ack;
    dvalid_nxt = dst_valid;
    ddata_nxt  = dst_data;
    unique case (dst_st)
      DST_IDLE: begin
        if (req_sync) begin
          ddata_nxt  = src_data_q;
          dvalid_nxt = 1'b1;
          dst_nxt    = DST_HOLD;
        end
      end
      DST_HOLD: begin
        if (dst_ready) begin
          dvalid_nxt = 1'b0;
          ack_nxt    = 1'b1;
          dst_nxt    = DST_ACK;
        end
      end
      DST_ACK: begin
        if (!req_sync) begin
          ack_nxt = 1'b0;
          dst_nxt = DST_IDLE;
        end
      end
      default: dst_nxt = DST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cdc_handshake_sync.sv
// Directed and randomized checks for cdc_handshake_sync.
// A queue scoreboard checks exact in-order single delivery.
`timescale 1ns/10ps
module tb_cdc_handshake_sync;

  logic        clk_src = 1'b0;
  logic        clk_dst = 1'b0;
  logic        rst_src, rst_dst;
  logic        src_valid, src_ready, src_busy;
  logic [31:0] src_data;
  logic        dst_valid, dst_ready;
  logic [31:0] dst_data;

  realtime hs = 5.0;
  realtime hd = 13.5;

  int tests = 0;
  int fails = 0;

  logic [31:0] q[$];
  logic        mon_en = 1'b0;
  int          acc = 0;
  int          dlv = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;

  always #(hs) clk_src = ~clk_src;
  always #(hd) clk_dst = ~clk_dst;

  cdc_handshake_sync #(.DATA_W(32)) dut (
    .clk_src   (clk_src),
    .rst_src   (rst_src),
    .clk_dst   (clk_dst),
    .rst_dst   (rst_dst),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_data  (src_data),
    .src_busy  (src_busy),
    .dst_valid (dst_valid),
    .dst_ready (dst_ready),
    .dst_data  (dst_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept seen at negedge happens on the following posedge
  always @(negedge clk_src) begin
    if (mon_en && rst_src && src_valid && src_ready) begin
      q.push_back(src_data);
      acc++;
    end
  end

  always @(negedge clk_dst) begin
    if (!mon_en) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("sb_valid_held", {31'd0, dst_valid}, 32'd1);
        chk("sb_data_stable", dst_data, prev_data);
      end
      if (dst_valid && dst_ready) begin
        chk("sb_q_nonempty", {31'd0, q.size() != 0}, 32'd1);
        if (q.size() != 0) chk("sb_data", dst_data, q.pop_front());
        dlv++;
      end
      prev_hold = dst_valid && !dst_ready;
      prev_data = dst_data;
    end
  end

  task automatic send_word(input logic [31:0] w);
    @(posedge clk_src);
    #0.2;
    chk("send_ready", {31'd0, src_ready}, 32'd1);
    src_valid = 1'b1;
    src_data  = w;
    @(posedge clk_src);
    #0.2;
    src_valid = 1'b0;
  endtask

  task automatic wait_dst_valid(input string tag);
    for (int i = 0; i < 40 && !dst_valid; i++) begin
      @(posedge clk_dst);
      #0.2;
    end
    chk(tag, {31'd0, dst_valid}, 32'd1);
  endtask

  task automatic consume();
    @(posedge clk_dst);
    #0.2;
    dst_ready = 1'b1;
    @(posedge clk_dst);
    #0.2;
    dst_ready = 1'b0;
  endtask

  initial begin
    logic        dup, saw_low;
    logic [31:0] held;
    realtime     dl;
    realtime     hds[4];
    hds[0] = 1.25; hds[1] = 3.7; hds[2] = 11.3; hds[3] = 20.0;

    rst_src = 1'b0; rst_dst = 1'b0;
    src_valid = 1'b0; dst_ready = 1'b0; src_data = '0;
    #20;
    chk("rst_src_ready", {31'd0, src_ready}, 32'd1);
    chk("rst_src_busy", {31'd0, src_busy}, 32'd0);
    chk("rst_dst_valid", {31'd0, dst_valid}, 32'd0);
    chk("rst_dst_data", dst_data, 32'd0);
    @(posedge clk_src); #0.2; rst_src = 1'b1;
    @(posedge clk_dst); #0.2; rst_dst = 1'b1;

    // Latency: E0 is the src edge that accepts and raises req
    @(posedge clk_src);
    #0.2;
    chk("lat_ready", {31'd0, src_ready}, 32'd1);
    src_valid = 1'b1;
    src_data  = 32'hDEADBEEF;
    @(posedge clk_src);
    #0.2;
    src_valid = 1'b0;
    chk("lat_busy", {31'd0, src_busy}, 32'd1);
    @(posedge clk_dst);
    @(posedge clk_dst);
    #0.2;
    chk("lat_not_yet", {31'd0, dst_valid}, 32'd0);
    @(posedge clk_dst);
    #0.2;
    chk("lat_valid", {31'd0, dst_valid}, 32'd1);
    chk("lat_data", dst_data, 32'hDEADBEEF);

    held = dst_data;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_dst);
      #0.2;
      chk("bp_valid", {31'd0, dst_valid}, 32'd1);
      chk("bp_data", dst_data, held);
      chk("bp_src_ready", {31'd0, src_ready}, 32'd0);
      chk("bp_src_busy", {31'd0, src_busy}, 32'd1);
    end
    consume();
    chk("bp_consumed", {31'd0, dst_valid}, 32'd0);
    for (int i = 0; i < 100 && src_busy; i++) @(posedge clk_src);
    #1;
    chk("bp_src_idle", {31'd0, src_busy}, 32'd0);
    chk("bp_src_ready_back", {31'd0, src_ready}, 32'd1);

    // Source reset while destination holds the word
    send_word(32'h12345678);
    wait_dst_valid("srst_hold");
    #3;
    rst_src = 1'b0;
    #2;
    chk("srst_ready", {31'd0, src_ready}, 32'd1);
    chk("srst_busy", {31'd0, src_busy}, 32'd0);
    @(posedge clk_src); #0.2; rst_src = 1'b1;
    chk("srst_dst_valid", {31'd0, dst_valid}, 32'd1);
    chk("srst_dst_data", dst_data, 32'h12345678);
    consume();
    dup = 1'b0;
    saw_low = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_src);
      dup     = dup | dst_valid;
      saw_low = saw_low | !src_ready;
    end
    chk("srst_no_dup", {31'd0, dup}, 32'd0);
    chk("srst_ready_withheld", {31'd0, saw_low}, 32'd1);
    chk("srst_ready_back", {31'd0, src_ready}, 32'd1);

    // Destination reset while source still requests
    send_word(32'h0000A5A5);
    wait_dst_valid("drst_first");
    #2;
    rst_dst = 1'b0;
    #2;
    chk("drst_valid_low", {31'd0, dst_valid}, 32'd0);
    chk("drst_data_zero", dst_data, 32'd0);
    chk("drst_src_busy", {31'd0, src_busy}, 32'd1);
    repeat (2) @(posedge clk_dst);
    #0.2;
    chk("drst_valid_held_low", {31'd0, dst_valid}, 32'd0);
    rst_dst = 1'b1;
    repeat (3) @(posedge clk_dst);
    #0.2;
    chk("drst_redeliver", {31'd0, dst_valid}, 32'd1);
    chk("drst_redata", dst_data, 32'h0000A5A5);
    consume();
    chk("drst_consumed", {31'd0, dst_valid}, 32'd0);
    dup = 1'b0;
    for (int i = 0; i < 100 && src_busy; i++) begin
      @(negedge clk_src);
      dup = dup | dst_valid;
    end
    chk("drst_no_dup", {31'd0, dup}, 32'd0);
    chk("drst_src_done", {31'd0, src_busy}, 32'd0);
    chk("drst_src_ready", {31'd0, src_ready}, 32'd1);

    // Random traffic over a sweep of clock ratios
    for (int r = 0; r < 4; r++) begin
      hd = hds[r];
      repeat (4) @(posedge clk_dst);
      acc = 0;
      dlv = 0;
      q.delete();
      mon_en = 1'b1;
      dl = $realtime + 400000.0;
      fork
        begin
          while (acc < 250 && $realtime < dl) begin
            @(posedge clk_src);
            #0.2;
            src_valid = (acc < 250) && ($urandom_range(0, 3) != 0);
            src_data  = $urandom;
          end
          src_valid = 1'b0;
        end
        begin
          while (dlv < 250 && $realtime < dl) begin
            @(posedge clk_dst);
            #0.2;
            dst_ready = 1'($urandom_range(0, 1));
          end
          dst_ready = 1'b0;
        end
      join
      chk("sweep_accepted", acc, 32'd250);
      chk("sweep_delivered", dlv, 32'd250);
      chk("sweep_q_empty", q.size(), 32'd0);
      for (int i = 0; i < 200 && src_busy; i++) @(posedge clk_src);
      #0.1;
      chk("sweep_src_idle", {31'd0, src_busy}, 32'd0);
      repeat (4) @(posedge clk_dst);
      #0.1;
      mon_en = 1'b0;
      chk("sweep_dst_idle", {31'd0, dst_valid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
